mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: STARVE_MAX, 3, number of consecutive data grants allowed while an instruction request waits; range 1..7.
REQ-002 Parameter: CPUID, 0, requester index reported in grant_id.
REQ-003 Port: CLK  in  1  single clock; all state updates on rising edge.
REQ-004 Port: nRST  in  1  asynchronous, active-low reset.
REQ-005 Port: iREN  in  1  instruction-cache read request.
REQ-006 Port: iaddr  in  32  instruction read address.
REQ-007 Port: iwait  out  1  high while the instruction request is not yet serviced.
REQ-008 Port: iload  out  32  instruction read data; valid only in the cycle iwait is low with iREN high.
REQ-009 Port: dREN, dWEN  in  1 each  data-cache read and write requests.
REQ-010 Port: daddr, dstore  in  32 each  data address and write data.
REQ-011 Port: dwait  out  1  high while the data request is not yet serviced.
REQ-012 Port: dload  out  32  data read data; valid only in the cycle dwait is low with dREN high.
REQ-013 Port: ramREN, ramWEN  out  1 each  RAM read and write strobes.
REQ-014 Port: ramaddr, ramstore  out  32 each  RAM address and write data.
REQ-015 Port: ramload  in  32  RAM read data.
REQ-016 Port: ramstate  in  2  encoding FREE=0, BUSY=1, ACCESS=2, ERROR=3.
REQ-017 Port: memerr  out  1  one-cycle pulse when a granted access ends in ERROR.
REQ-018 Port: starve_cnt  out  3  current consecutive-data-grant count, for debug.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, IGRANT and DGRANT, held in a state register.
REQ-020 In IDLE, the FSM SHALL select DGRANT when (dREN|dWEN) is high, unless iREN is high and starve_cnt==STARVE_MAX, in which case it SHALL select IGRANT.
REQ-021 In IDLE with no data request and iREN high, the FSM SHALL select IGRANT; with no requests it SHALL stay in IDLE.
REQ-022 In IDLE, all RAM strobes SHALL be 0 and iwait/dwait SHALL equal iREN/(dREN|dWEN) respectively. A request therefore sees at least one wait cycle.
REQ-023 In IGRANT: ramREN=1, ramWEN=0, ramaddr=iaddr, dwait=(dREN|dWEN).
REQ-024 In DGRANT: ramWEN=dWEN, ramREN=dREN&~dWEN (write wins if both are high), ramaddr=daddr, ramstore=dstore, iwait=iREN.
REQ-025 In a granted state, when ramstate is ACCESS: the granted requester's wait SHALL be 0 that cycle, its load SHALL equal ramload combinationally, and the next state SHALL be IDLE.
REQ-026 In a granted state, when ramstate is ERROR: the granted wait SHALL be 0, memerr SHALL be 1 for that cycle, and the next state SHALL be IDLE.
REQ-027 When ramstate is FREE or BUSY, the FSM SHALL remain in the granted state with the granted wait high.
REQ-028 If the granted requester deasserts its request before ACCESS, the FSM SHALL return to IDLE next cycle. RAM strobes SHALL drop that same cycle, and the count update of REQ-029/030 SHALL NOT apply.
REQ-029 On DGRANT completion, starve_cnt SHALL increment by 1, saturating at STARVE_MAX, if iREN is high; otherwise it SHALL clear to 0.
REQ-030 On IGRANT completion, starve_cnt SHALL clear to 0.
REQ-031 iload/dload SHALL be 0 whenever not valid per REQ-008/012. ramstore SHALL be 0 outside DGRANT, and ramaddr SHALL be 0 in IDLE.
REQ-032 Back-to-back accesses SHALL pass through one IDLE cycle between grants. There SHALL be no combinational path from ramstate to the state register other than through next-state logic.

Reset
REQ-033 While nRST=0 (asynchronously), state SHALL be IDLE, starve_cnt=0, memerr=0, and all RAM strobes SHALL be 0.
REQ-034 Reset asserted mid-grant SHALL abort the access immediately. No wait deassertion or memerr SHALL occur for that access.
REQ-035 In the first edge after nRST rises, arbitration SHALL proceed per REQ-020.

Verification
REQ-036 iREN=1, iaddr=0x40, RAM ACCESS after 2 BUSY cycles with ramload=0xDEADBEEF -> ramREN=1 ramaddr=0x40 for 3 cycles; iwait=0 and iload=0xDEADBEEF in cycle 3; IDLE next.
REQ-037 iREN and dWEN both high, daddr=0x80, dstore=0x1234, starve_cnt=0 -> DGRANT first (ramWEN=1, ramstore=0x1234); IGRANT after one IDLE cycle; starve_cnt=1 then 0.
REQ-038 STARVE_MAX=3, dREN held high continuously with iREN high, each access completing in 1 cycle -> three data grants, then IGRANT; starve_cnt sequence 1,2,3,0.
REQ-039 DGRANT with ramstate=ERROR -> dwait=0 and memerr=1 for one cycle; starve_cnt updates per REQ-029.
REQ-040 nRST pulsed low during IGRANT with ramstate BUSY -> ramREN=0 immediately; iwait stays high; IGRANT re-entered one cycle after release.
REQ-041 dREN dropped while in DGRANT with ramstate BUSY -> strobes 0 that cycle; IDLE next; starve_cnt unchanged.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester RAM arbiter: one instruction-cache port and one data-cache
// port share a single RAM.
// Data requests normally win. After STARVE_MAX back-to-back data grants with
// an instruction request waiting, the instruction port gets the RAM.
module mem_arbiter #(
    parameter int unsigned STARVE_MAX = 3,
    parameter int unsigned CPUID      = 0
) (
    input  logic        CLK,
    input  logic        nRST,
    // instruction cache side
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    // data cache side
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    // RAM side
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    // status
    output logic        memerr,
    output logic [2:0]  starve_cnt,
    output logic [31:0] grant_id
);

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;
    localparam logic [2:0] CNT_MAX    = 3'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE,
        IGRANT,
        DGRANT
    } state_t;

    state_t state, next_state;
    logic   d_req;
    logic   i_done;
    logic   d_done;

    assign d_req    = dREN | dWEN;
    assign grant_id = 32'(CPUID);

    // State register; reset abandons any access in flight.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Count of consecutive data grants completed while the instruction port waits.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            starve_cnt <= 3'd0;
        end else if (d_done) begin
            if (!iREN) begin
                starve_cnt <= 3'd0;
            end else if (starve_cnt != CNT_MAX) begin
                starve_cnt <= starve_cnt + 3'd1;
            end
        end else if (i_done) begin
            starve_cnt <= 3'd0;
        end
    end

    // Next-state selection plus all RAM strobes, wait and load outputs.
    always_comb begin
        next_state = state;
        iwait      = iREN;
        dwait      = d_req;
        iload      = 32'd0;
        dload      = 32'd0;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = 32'd0;
        ramstore   = 32'd0;
        memerr     = 1'b0;
        i_done     = 1'b0;
        d_done     = 1'b0;

        unique case (state)
            IDLE: begin
                if (d_req && !(iREN && (starve_cnt == CNT_MAX))) begin
                    next_state = DGRANT;
                end else if (iREN) begin
                    next_state = IGRANT;
                end
            end

            IGRANT: begin
                if (!iREN) begin
                    next_state = IDLE;
                end else begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr;
                    if (ramstate == RAM_ACCESS || ramstate == RAM_ERROR) begin
                        iwait      = 1'b0;
                        iload      = ramload;
                        memerr     = (ramstate == RAM_ERROR);
                        i_done     = 1'b1;
                        next_state = IDLE;
                    end
                end
            end

            DGRANT: begin
                if (!d_req) begin
                    next_state = IDLE;
                end else begin
                    ramWEN   = dWEN;
                    ramREN   = dREN & ~dWEN;
                    ramaddr  = daddr;
                    ramstore = dstore;
                    if (ramstate == RAM_ACCESS || ramstate == RAM_ERROR) begin
                        dwait      = 1'b0;
                        dload      = dREN ? ramload : 32'd0;
                        memerr     = (ramstate == RAM_ERROR);
                        d_done     = 1'b1;
                        next_state = IDLE;
                    end
                end
            end

            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with hand-computed expectations.
module tb_mem_arbiter;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic        memerr;
    logic [2:0]  starve_cnt;
    logic [31:0] grant_id;

    int totalChecks = 0;
    int badChecks   = 0;

    localparam logic [1:0] FREE   = 2'd0;
    localparam logic [1:0] BUSY   = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] ERROR  = 2'd3;

    mem_arbiter #(.STARVE_MAX(3), .CPUID(0)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
        .memerr(memerr), .starve_cnt(starve_cnt), .grant_id(grant_id)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, observed, expected);
        end
    endtask

    // Move just past the next rising edge.
    task automatic nextCycle();
        @(posedge CLK);
        #2;
    endtask

    // Drive the request/control inputs, then let combinational outputs settle.
    task automatic applyStimulus(input logic iren, input logic dren,
                                 input logic dwen, input logic [1:0] rstate);
        iREN     = iren;
        dREN     = dren;
        dWEN     = dwen;
        ramstate = rstate;
        #1;
    endtask

    // Watchdog so the run always ends.
    initial begin
        #20000;
        $display("[TB] FAIL watchdog: got timeout, want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        nRST = 1'b0;
        iaddr = 32'd0; daddr = 32'd0; dstore = 32'd0; ramload = 32'd0;
        applyStimulus(1'b0, 1'b0, 1'b0, FREE);
        checkOutput("rst_ramREN", 32'(ramREN), 32'd0);
        checkOutput("rst_ramWEN", 32'(ramWEN), 32'd0);
        checkOutput("rst_starve", 32'(starve_cnt), 32'd0);
        checkOutput("rst_memerr", 32'(memerr), 32'd0);
        checkOutput("grant_id", grant_id, 32'd0);
        nextCycle();
        nRST = 1'b1;

        // Instruction read: two BUSY cycles then ACCESS.
        iaddr = 32'h40;
        applyStimulus(1'b1, 1'b0, 1'b0, BUSY);
        checkOutput("i_idle_iwait", 32'(iwait), 32'd1);
        checkOutput("i_idle_ramREN", 32'(ramREN), 32'd0);
        checkOutput("i_idle_ramaddr", ramaddr, 32'd0);
        for (int k = 0; k < 2; k++) begin
            nextCycle(); #1;
            checkOutput("i_busy_ramREN", 32'(ramREN), 32'd1);
            checkOutput("i_busy_ramaddr", ramaddr, 32'h40);
            checkOutput("i_busy_iwait", 32'(iwait), 32'd1);
            checkOutput("i_busy_iload", iload, 32'd0);
        end
        nextCycle();
        ramload = 32'hDEADBEEF;
        applyStimulus(1'b1, 1'b0, 1'b0, ACCESS);
        checkOutput("i_acc_ramREN", 32'(ramREN), 32'd1);
        checkOutput("i_acc_iwait", 32'(iwait), 32'd0);
        checkOutput("i_acc_iload", iload, 32'hDEADBEEF);
        checkOutput("i_acc_memerr", 32'(memerr), 32'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, ACCESS);
        checkOutput("i_after_ramREN", 32'(ramREN), 32'd0);
        checkOutput("i_after_iload", iload, 32'd0);

        // Simultaneous write and instruction read: data first, then instruction.
        daddr = 32'h80; dstore = 32'h1234; iaddr = 32'h44; ramload = 32'hCAFEF00D;
        applyStimulus(1'b1, 1'b0, 1'b1, ACCESS);
        checkOutput("both_idle_dwait", 32'(dwait), 32'd1);
        checkOutput("both_idle_ramWEN", 32'(ramWEN), 32'd0);
        nextCycle(); #1;
        checkOutput("dg_ramWEN", 32'(ramWEN), 32'd1);
        checkOutput("dg_ramREN", 32'(ramREN), 32'd0);
        checkOutput("dg_ramaddr", ramaddr, 32'h80);
        checkOutput("dg_ramstore", ramstore, 32'h1234);
        checkOutput("dg_dwait", 32'(dwait), 32'd0);
        checkOutput("dg_iwait", 32'(iwait), 32'd1);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 1'b0, ACCESS);
        checkOutput("dg_starve1", 32'(starve_cnt), 32'd1);
        checkOutput("gap_ramstore", ramstore, 32'd0);
        nextCycle(); #1;
        checkOutput("ig_ramREN", 32'(ramREN), 32'd1);
        checkOutput("ig_ramaddr", ramaddr, 32'h44);
        checkOutput("ig_iload", iload, 32'hCAFEF00D);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, ACCESS);
        checkOutput("ig_starve0", 32'(starve_cnt), 32'd0);

        // Starvation limit: three data grants, then the instruction port.
        daddr = 32'hA0; iaddr = 32'h48; ramload = 32'h55;
        applyStimulus(1'b1, 1'b1, 1'b0, ACCESS);
        for (int k = 1; k <= 3; k++) begin
            nextCycle(); #1;
            checkOutput("stv_d_ramaddr", ramaddr, 32'hA0);
            checkOutput("stv_d_dload", dload, 32'h55);
            nextCycle(); #1;
            checkOutput("stv_cnt", 32'(starve_cnt), 32'(k));
        end
        nextCycle(); #1;
        checkOutput("stv_i_ramaddr", ramaddr, 32'h48);
        checkOutput("stv_i_iwait", 32'(iwait), 32'd0);
        checkOutput("stv_i_dwait", 32'(dwait), 32'd1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, ACCESS);
        checkOutput("stv_cnt_clr", 32'(starve_cnt), 32'd0);

        // Data read ends in ERROR.
        applyStimulus(1'b1, 1'b1, 1'b0, ERROR);
        nextCycle(); #1;
        checkOutput("err_dwait", 32'(dwait), 32'd0);
        checkOutput("err_memerr", 32'(memerr), 32'd1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, ERROR);
        checkOutput("err_memerr_gone", 32'(memerr), 32'd0);
        checkOutput("err_starve", 32'(starve_cnt), 32'd1);

        // Data request withdrawn while RAM is busy.
        daddr = 32'h90;
        applyStimulus(1'b0, 1'b1, 1'b0, BUSY);
        nextCycle(); #1;
        checkOutput("wd_ramREN", 32'(ramREN), 32'd1);
        checkOutput("wd_ramaddr", ramaddr, 32'h90);
        checkOutput("wd_dwait", 32'(dwait), 32'd1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, BUSY);
        checkOutput("wd_drop_ramREN", 32'(ramREN), 32'd0);
        checkOutput("wd_drop_ramaddr", ramaddr, 32'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 1'b0, BUSY);
        checkOutput("wd_idle_ramREN", 32'(ramREN), 32'd0);
        checkOutput("wd_idle_dwait", 32'(dwait), 32'd1);
        checkOutput("wd_starve", 32'(starve_cnt), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, BUSY);

        // Reset asserted during an instruction grant.
        iaddr = 32'h40;
        applyStimulus(1'b1, 1'b0, 1'b0, BUSY);
        nextCycle(); #1;
        checkOutput("rg_ramREN", 32'(ramREN), 32'd1);
        nRST = 1'b0;
        #1;
        checkOutput("rg_rst_ramREN", 32'(ramREN), 32'd0);
        checkOutput("rg_rst_iwait", 32'(iwait), 32'd1);
        checkOutput("rg_rst_starve", 32'(starve_cnt), 32'd0);
        checkOutput("rg_rst_memerr", 32'(memerr), 32'd0);
        nextCycle();
        nRST = 1'b1;
        #1;
        checkOutput("rg_rel_ramREN", 32'(ramREN), 32'd0);
        nextCycle(); #1;
        checkOutput("rg_re_ramREN", 32'(ramREN), 32'd1);
        checkOutput("rg_re_ramaddr", ramaddr, 32'h40);
        checkOutput("rg_re_iwait", 32'(iwait), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, FREE);
        nextCycle();

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
